// File: rtl/wb_spi_seq_pkg.sv
// Shared definitions for the SPI byte sequencer.
// Holds the SPI master register offsets, the status "run" bit position,
// the Wishbone byte-select used for every access, and the sequencer states.
// Optional feature macro used across this slice: WB_SPI_SEQ_TIMEOUT_EN.
package wb_spi_seq_pkg;

  localparam logic [31:0] REG_DATA = 32'h0;
  localparam logic [31:0] REG_STAT = 32'h4;
  localparam logic [31:0] REG_CS   = 32'h8;
  localparam logic [31:0] REG_DIV  = 32'hC;

  localparam int STAT_RUN = 0;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR_CS,
    ST_WR_DAT,
    ST_POLL,
    ST_RD_DAT,
    ST_PUSH
  } seq_state_e;

endpackage

// File: rtl/wb_spi_seq_wbm_single.sv
// wbm_single: runs one Wishbone classic access at a time.
// Ports:
//   clk, reset (async, active-low)
//   req/req_we/req_adr/req_wdat : access request, held by the caller until done/timeout
//   done     : pulses in the ack cycle; rdata is valid in that same cycle
//   rdata    : read data (wbm_dat_i passed through for capture on done)
//   timeout  : pulses when an access is abandoned (only with WB_SPI_SEQ_TIMEOUT_EN)
//   wbm_*    : Wishbone master interface
// Since cyc/stb are registered and drop on the ack edge, a new request can
// start no earlier than the edge after that, which gives the one idle cycle
// the registered-ack slave needs.
// Macro WB_SPI_SEQ_TIMEOUT_EN adds the TIMEOUT parameter and the wait counter.
module wbm_single
  import wb_spi_seq_pkg::*;
`ifdef WB_SPI_SEQ_TIMEOUT_EN
#(
  parameter logic [15:0] TIMEOUT = 16'd1023
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wdat,
  output logic        done,
  output logic [31:0] rdata,
  output logic        timeout,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic        wbm_ack_i
);

  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        expire;

`ifdef WB_SPI_SEQ_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counter counts cycles stb has waited for ack; expiry after TIMEOUT cycles.
  assign expire = stb_q & ~wbm_ack_i & (cnt_q == (TIMEOUT - 16'd1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    cyc_d = cyc_q;
    stb_d = stb_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    sel_d = sel_q;
    if (!stb_q) begin
      if (req) begin
        cyc_d = 1'b1;
        stb_d = 1'b1;
        we_d  = req_we;
        adr_d = req_adr;
        dat_d = req_we ? req_wdat : 32'h0;
        sel_d = WB_SEL_ALL;
      end
    end else if (wbm_ack_i || expire) begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
      we_d  = 1'b0;
      sel_d = 4'h0;
    end
  end

`ifdef WB_SPI_SEQ_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (!stb_q) begin
      cnt_d = 16'h0;
    end else if (!wbm_ack_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'h0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= 32'h0;
      dat_q <= 32'h0;
      sel_q <= 4'h0;
    end else begin
      cyc_q <= cyc_d;
      stb_q <= stb_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
    end
  end

  assign done      = stb_q & wbm_ack_i;
  assign timeout   = expire;
  assign rdata     = wbm_dat_i;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;

endmodule

// File: rtl/wb_spi_seq.sv
// wb_spi_seq: hardware byte sequencer driving a Wishbone SPI master.
// Ports:
//   clk, reset (async, active-low)
//   tx_data/tx_cs/tx_valid/tx_ready : byte + chip-select stream in
//   rx_data/rx_valid/rx_ready       : received byte stream out
//   wbm_*                           : Wishbone master towards the SPI master
//   busy : high whenever the sequencer is not idle
//   err  : sticky bus-timeout flag (constant 0 without WB_SPI_SEQ_TIMEOUT_EN)
// Each byte costs: CS write, data write, status polls until run clears,
// data read. CS is rewritten every byte because the SPI master releases CS
// after each transfer.
// Macro WB_SPI_SEQ_TIMEOUT_EN enables the TIMEOUT parameter and err.
module wb_spi_seq
  import wb_spi_seq_pkg::*;
#(
  parameter int          CS_WIDTH = 4,
  parameter logic [31:0] BASE_ADR = 32'h0,
  parameter logic [7:0]  DIVISOR  = 8'hFF
`ifdef WB_SPI_SEQ_TIMEOUT_EN
  ,
  parameter logic [15:0] TIMEOUT  = 16'd1023
`endif
)
(
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          tx_data,
  input  logic [CS_WIDTH-1:0] tx_cs,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [7:0]          rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic [31:0]         wbm_adr_o,
  output logic [31:0]         wbm_dat_o,
  input  logic [31:0]         wbm_dat_i,
  output logic [3:0]          wbm_sel_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  input  logic                wbm_ack_i,
  output logic                busy,
  output logic                err
);

  seq_state_e          state_q, state_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [CS_WIDTH-1:0] tx_cs_q, tx_cs_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;

  logic        req;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_wdat;
  logic        done;
  logic [31:0] rdata;
  logic        timeout;
  logic        unused_rdata_hi;

  assign unused_rdata_hi = ^rdata[31:8];

  wbm_single
`ifdef WB_SPI_SEQ_TIMEOUT_EN
  #(
    .TIMEOUT(TIMEOUT)
  )
`endif
  u_wbm (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_wdat  (req_wdat),
    .done      (done),
    .rdata     (rdata),
    .timeout   (timeout),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_sel_o (wbm_sel_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_ack_i (wbm_ack_i)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // A timeout in any bus state abandons the byte and returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (done || timeout) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (tx_valid && tx_ready) state_d = ST_WR_CS;
      end
      ST_WR_CS: begin
        if (timeout)   state_d = ST_IDLE;
        else if (done) state_d = ST_WR_DAT;
      end
      ST_WR_DAT: begin
        if (timeout)   state_d = ST_IDLE;
        else if (done) state_d = ST_POLL;
      end
      ST_POLL: begin
        if (timeout)                        state_d = ST_IDLE;
        else if (done && !rdata[STAT_RUN]) state_d = ST_RD_DAT;
      end
      ST_RD_DAT: begin
        if (timeout)   state_d = ST_IDLE;
        else if (done) state_d = ST_PUSH;
      end
      ST_PUSH: begin
        if (rx_valid_q && rx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    req      = 1'b0;
    req_we   = 1'b0;
    req_adr  = BASE_ADR;
    req_wdat = 32'h0;
    tx_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      ST_INIT: begin
        req      = 1'b1;
        req_we   = 1'b1;
        req_adr  = BASE_ADR + REG_DIV;
        req_wdat = {24'h0, DIVISOR};
      end
      ST_IDLE: begin
        busy     = 1'b0;
        tx_ready = ~rx_valid_q;
      end
      ST_WR_CS: begin
        req      = 1'b1;
        req_we   = 1'b1;
        req_adr  = BASE_ADR + REG_CS;
        req_wdat = {{(32-CS_WIDTH){1'b0}}, tx_cs_q};
      end
      ST_WR_DAT: begin
        req      = 1'b1;
        req_we   = 1'b1;
        req_adr  = BASE_ADR + REG_DATA;
        req_wdat = {24'h0, tx_data_q};
      end
      ST_POLL: begin
        req     = 1'b1;
        req_adr = BASE_ADR + REG_STAT;
      end
      ST_RD_DAT: begin
        req     = 1'b1;
        req_adr = BASE_ADR + REG_DATA;
      end
      default: begin
        req = 1'b0;
      end
    endcase
  end

  always_comb begin
    tx_data_d  = tx_data_q;
    tx_cs_d    = tx_cs_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (state_q == ST_IDLE && tx_valid && tx_ready) begin
      tx_data_d = tx_data;
      tx_cs_d   = tx_cs;
    end
    if (state_q == ST_RD_DAT && done) begin
      rx_data_d  = rdata[7:0];
      rx_valid_d = 1'b1;
    end
    if (state_q == ST_PUSH && rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data_q  <= 8'h0;
      tx_cs_q    <= '0;
      rx_data_q  <= 8'h0;
      rx_valid_q <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_cs_q    <= tx_cs_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

`ifdef WB_SPI_SEQ_TIMEOUT_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | timeout;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_wb_spi_seq.sv
// Self-checking bench for wb_spi_seq.
// A behavioural Wishbone SPI-master model (registered ack, MISO looped to
// MOSI, configurable number of busy status polls) logs every access; the
// expected access list, rx byte and latency of each byte are derived from
// the sequencer's rules and compared against what the model observed.
// With WB_SPI_SEQ_TIMEOUT_EN defined a stuck-ack timeout scenario also runs.
module tb_wb_spi_seq;

  localparam int          CS_WIDTH = 4;
  localparam logic [31:0] BASE     = 32'h0000_4000;
  localparam logic [7:0]  DIV      = 8'h03;
  localparam logic [15:0] TMO      = 16'd16;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } acc_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [7:0]          tx_data = 8'h0;
  logic [CS_WIDTH-1:0] tx_cs = '0;
  logic                tx_valid = 1'b0;
  logic                tx_ready;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_ready = 1'b0;
  logic [31:0]         wbm_adr_o;
  logic [31:0]         wbm_dat_o;
  logic [31:0]         wbm_dat_i = 32'h0;
  logic [3:0]          wbm_sel_o;
  logic                wbm_cyc_o;
  logic                wbm_stb_o;
  logic                wbm_we_o;
  logic                wbm_ack_i = 1'b0;
  logic                busy;
  logic                err;

  int checks = 0;
  int errors = 0;

  logic  ack_en = 1'b1;
  int    polls_cfg = 0;
  int    busy_cnt = 0;
  logic [7:0]  shift_byte = 8'h0;
  logic [31:0] garbage;
  acc_t  log_q[$];

  logic prev_ack = 1'b0;
  int   gap_err = 0;
  int   sel_err = 0;

  always #5 clk = ~clk;

  wb_spi_seq #(
    .CS_WIDTH (CS_WIDTH),
    .BASE_ADR (BASE),
    .DIVISOR  (DIV)
`ifdef WB_SPI_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT  (TMO)
`endif
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .tx_data   (tx_data),
    .tx_cs     (tx_cs),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_sel_o (wbm_sel_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_ack_i (wbm_ack_i),
    .busy      (busy),
    .err       (err)
  );

  // SPI master model: registered ack, data write starts a transfer that
  // stays busy for polls_cfg status reads, data read returns the looped byte.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbm_ack_i <= 1'b0;
      wbm_dat_i <= 32'h0;
      busy_cnt  <= 0;
    end else begin
      wbm_ack_i <= 1'b0;
      if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && ack_en) begin
        wbm_ack_i <= 1'b1;
        log_q.push_back('{wbm_we_o, wbm_adr_o, wbm_we_o ? wbm_dat_o : 32'h0});
        garbage = $urandom;
        if (wbm_we_o && wbm_adr_o == BASE) begin
          shift_byte <= wbm_dat_o[7:0];
          busy_cnt   <= polls_cfg;
        end
        if (!wbm_we_o && wbm_adr_o == BASE + 32'h4) begin
          wbm_dat_i <= {garbage[31:1], busy_cnt != 0};
          if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        end
        if (!wbm_we_o && wbm_adr_o == BASE) begin
          wbm_dat_i <= {garbage[31:8], shift_byte};
        end
      end
    end
  end

  // Bus protocol watch: cyc must drop on the ack edge, sel is all-ones
  // during an access and cyc/stb move together.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_ack && wbm_cyc_o) gap_err++;
      if (wbm_stb_o && wbm_sel_o != 4'hF) sel_err++;
      if (wbm_cyc_o != wbm_stb_o) sel_err++;
    end
    prev_ack = wbm_ack_i;
  end

  task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic acc_t mkAcc(input logic we, input logic [31:0] off, input logic [31:0] d);
    mkAcc = '{we, BASE + off, d};
  endfunction

  // Offer one byte, wait for acceptance, then wait for rx_valid and report
  // how many cycles after the handshake edge it appeared.
  task automatic applyStimulus(input logic [7:0] d, input logic [3:0] cs, input int polls,
                               output int lat, output logic got);
    logic ok;
    polls_cfg = polls;
    lat = 0;
    got = 1'b0;
    ok  = 1'b0;
    @(negedge clk);
    tx_data  = d;
    tx_cs    = cs;
    tx_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("tx_accept", {71'h0, ok}, 72'h1);
    if (ok) begin
      @(posedge clk);
      #1 tx_valid = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (rx_valid) begin
          got = 1'b1;
          break;
        end
        lat++;
      end
    end else begin
      tx_valid = 1'b0;
    end
  endtask

  task automatic popRx(input int delay);
    repeat (delay) @(negedge clk);
    rx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_ready = 1'b0;
    checkOutput("pop_rx_valid", {71'h0, rx_valid}, 72'h0);
    checkOutput("pop_tx_ready", {71'h0, tx_ready}, 72'h1);
  endtask

  // Reference for one byte: CS write, data write, polls+1 status reads,
  // data read; each access takes two cycles plus one idle cycle.
  task automatic checkByte(input string name, input logic [7:0] d, input logic [3:0] cs,
                           input int polls, input int lat, input logic got, input int start);
    acc_t exp_q[$];
    exp_q.push_back(mkAcc(1'b1, 32'h8, {28'h0, cs}));
    exp_q.push_back(mkAcc(1'b1, 32'h0, {24'h0, d}));
    for (int p = 0; p <= polls; p++) exp_q.push_back(mkAcc(1'b0, 32'h4, 32'h0));
    exp_q.push_back(mkAcc(1'b0, 32'h0, 32'h0));
    checkOutput({name, "_arrive"}, {71'h0, got}, 72'h1);
    checkOutput({name, "_rx_data"}, {64'h0, rx_data}, {64'h0, d});
    checkOutput({name, "_latency"}, 72'(lat), 72'(3 * exp_q.size()));
    checkOutput({name, "_n_access"}, 72'(log_q.size() - start), 72'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (start + k < log_q.size())
        checkOutput($sformatf("%s_acc%0d", name, k), {7'h0, log_q[start + k]}, {7'h0, exp_q[k]});
    end
  endtask

  initial begin
    int   lat;
    logic got;
    int   start;
    int   bad;
    int   n;
    logic ok;
    logic [7:0] d;
    logic [3:0] cs;
    int   polls;
    logic [7:0] seq_d[2];

    $display("[TB] start");
    repeat (2) @(negedge clk);
    checkOutput("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o},
                {72'h0});
    checkOutput("rst_adr_dat", {8'h0, wbm_adr_o, wbm_dat_o}, 72'h0);
    checkOutput("rst_stream", {tx_ready, rx_valid, rx_data}, 72'h0);
    checkOutput("rst_busy_err", {busy, err}, 72'h2);

    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("init_done", {71'h0, ok}, 72'h1);
    checkOutput("init_n_access", 72'(log_q.size()), 72'h1);
    if (log_q.size() > 0)
      checkOutput("init_div_write", {7'h0, log_q[0]}, {7'h0, mkAcc(1'b1, 32'hC, 32'h3)});
    checkOutput("init_tx_ready", {71'h0, tx_ready}, 72'h1);

    start = log_q.size();
    applyStimulus(8'hA5, 4'b1110, 2, lat, got);
    checkByte("a5", 8'hA5, 4'b1110, 2, lat, got, start);
    n = log_q.size();
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!rx_valid || rx_data != 8'hA5 || tx_ready || wbm_cyc_o) bad++;
    end
    checkOutput("hold_stable", 72'(bad), 72'h0);
    checkOutput("hold_no_bus", 72'(log_q.size() - n), 72'h0);
    popRx(0);

    seq_d[0] = 8'h01;
    seq_d[1] = 8'h02;
    for (int b = 0; b < 2; b++) begin
      start = log_q.size();
      applyStimulus(seq_d[b], 4'b1101, b, lat, got);
      checkByte($sformatf("b2b%0d", b), seq_d[b], 4'b1101, b, lat, got, start);
      popRx(0);
    end

    for (int t = 0; t < 16; t++) begin
      d     = 8'($urandom);
      cs    = 4'($urandom);
      polls = $urandom_range(0, 3);
      start = log_q.size();
      applyStimulus(d, cs, polls, lat, got);
      checkByte($sformatf("rnd%0d", t), d, cs, polls, lat, got, start);
      popRx($urandom_range(0, 3));
    end
    checkOutput("err_clear", {71'h0, err}, 72'h0);

`ifdef WB_SPI_SEQ_TIMEOUT_EN
    ack_en = 1'b0;
    @(negedge clk);
    tx_data  = 8'h5A;
    tx_cs    = 4'b0111;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wbm_stb_o) n++;
      if (rx_valid) got = 1'b1;
      if (!busy && n > 0) break;
    end
    checkOutput("tmo_stb_cycles", 72'(n), 72'(TMO));
    checkOutput("tmo_err", {71'h0, err}, 72'h1);
    checkOutput("tmo_no_rx", {71'h0, got}, 72'h0);
    checkOutput("tmo_tx_ready", {71'h0, tx_ready}, 72'h1);
    ack_en = 1'b1;
`endif

    polls_cfg = 30;
    @(negedge clk);
    tx_data  = 8'h3C;
    tx_cs    = 4'b1011;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (log_q.size() > 0 && log_q[$].adr == BASE + 32'h4 && !log_q[$].we && wbm_cyc_o) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("poll_reached", {71'h0, ok}, 72'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_bus", {wbm_cyc_o, wbm_stb_o, busy}, 72'h1);
    repeat (2) @(negedge clk);
    log_q.delete();
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("reinit_done", {71'h0, ok}, 72'h1);
    checkOutput("reinit_n_access", 72'(log_q.size()), 72'h1);
    if (log_q.size() > 0)
      checkOutput("reinit_div_write", {7'h0, log_q[0]}, {7'h0, mkAcc(1'b1, 32'hC, 32'h3)});
    checkOutput("reinit_err", {71'h0, err}, 72'h0);
    checkOutput("reinit_rx_valid", {71'h0, rx_valid}, 72'h0);

    checkOutput("ack_gap", 72'(gap_err), 72'h0);
    checkOutput("sel_cyc_stb", 72'(sel_err), 72'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
